// File: rtl/id_fetch_arbiter.sv
// Fetch-entry arbiter for the ID-stage decode slot: sticky round-robin among
// NrSrc sources, bounded by MaxBurst, with a one-entry output register and per-source flush.
module id_fetch_arbiter #(
  parameter int unsigned NrSrc      = 2,
  parameter int unsigned EntryWidth = 64,
  parameter int unsigned MaxBurst   = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NrSrc-1:0]            flush_i,
  input  logic                        hold_i,
  input  logic [NrSrc-1:0]            src_valid_i,
  input  logic [NrSrc*EntryWidth-1:0] src_entry_i,
  output logic [NrSrc-1:0]            src_ready_o,
  output logic                        id_valid_o,
  output logic [EntryWidth-1:0]       id_entry_o,
  output logic [$clog2(NrSrc)-1:0]    id_src_o,
  input  logic                        id_ready_i
);

  localparam int unsigned IdxW   = $clog2(NrSrc);
  localparam int unsigned BurstW = $clog2(MaxBurst + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MaxBurst);

  logic [IdxW-1:0]       last_q;
  logic [BurstW-1:0]     burst_q;
  logic [BurstW-1:0]     burst_d;
  logic [IdxW-1:0]       start;
  logic [IdxW-1:0]       cand;
  logic [IdxW-1:0]       grant_idx;
  logic [NrSrc-1:0]      req;
  logic [EntryWidth-1:0] grant_entry;
  logic                  space;
  logic                  rotate;
  logic                  grant_vld;
  logic                  load;
  int unsigned           sum;

  assign req   = src_valid_i & ~flush_i;
  assign space = !id_valid_o || id_ready_i;

  // Stay on last_q while it still requests and has burst budget; hold pins it there.
  always_comb begin
    rotate = 1'b0;
    start  = last_q;
    if (!hold_i && !(req[last_q] && burst_q < BurstMax)) begin
      rotate = 1'b1;
      start  = (last_q == IdxW'(NrSrc - 1)) ? '0 : last_q + IdxW'(1);
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    sum       = 0;
    for (int unsigned i = 0; i < NrSrc; i++) begin
      sum = 32'(start) + i;
      if (sum >= NrSrc) sum = sum - NrSrc;
      cand = IdxW'(sum);
      if (!grant_vld && req[cand] && (!hold_i || cand == last_q)) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign load = space && grant_vld && !rst_i;

  // A forced rotation that wraps back to last_q counts as a fresh burst.
  always_comb begin
    if (grant_idx == last_q && !rotate)
      burst_d = (burst_q == BurstMax) ? burst_q : burst_q + BurstW'(1);
    else
      burst_d = BurstW'(1);
  end

  always_comb begin
    src_ready_o = '0;
    grant_entry = '0;
    for (int unsigned s = 0; s < NrSrc; s++) begin
      if (grant_idx == IdxW'(s)) begin
        src_ready_o[s] = load;
        grant_entry    = src_entry_i[s*EntryWidth +: EntryWidth];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_valid_o <= 1'b0;
      id_entry_o <= '0;
      id_src_o   <= '0;
      last_q     <= '0;
      burst_q    <= '0;
    end else if (load) begin
      id_valid_o <= 1'b1;
      id_entry_o <= grant_entry;
      id_src_o   <= grant_idx;
      last_q     <= grant_idx;
      burst_q    <= burst_d;
    end else if (id_valid_o && (id_ready_i || flush_i[id_src_o])) begin
      id_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_fetch_arbiter.sv
// Randomized and directed checks of id_fetch_arbiter against a behavioural
// model of the grant rules (stay/rotate, burst limit, hold, flush, stall).
module tb_id_fetch_arbiter;

  localparam int NR = 2;
  localparam int EW = 64;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   flush;
  logic            hold;
  logic [NR-1:0]   valid;
  logic [NR*EW-1:0] entries;
  logic [NR-1:0]   src_ready_o;
  logic            id_valid_o;
  logic [EW-1:0]   id_entry_o;
  logic [0:0]      id_src_o;
  logic            id_ready;

  int checks = 0;
  int errors = 0;

  // Model state and per-cycle prediction
  int          m_last, m_burst, m_src;
  bit          m_valid;
  logic [EW-1:0] m_entry;
  int          g;
  bit          stay, load;
  logic [NR-1:0] exp_rdy;

  id_fetch_arbiter #(.NrSrc(NR), .EntryWidth(EW), .MaxBurst(MB)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .hold_i(hold),
    .src_valid_i(valid), .src_entry_i(entries), .src_ready_o(src_ready_o),
    .id_valid_o(id_valid_o), .id_entry_o(id_entry_o), .id_src_o(id_src_o),
    .id_ready_i(id_ready)
  );

  always #5 clk = ~clk;

  // Predict this cycle's grant from the current inputs (sampled at negedge).
  task automatic eval();
    logic [NR-1:0] req;
    @(negedge clk);
    req = valid & ~flush;
    g = -1;
    stay = 0;
    if (hold) begin
      if (req[m_last]) begin g = m_last; stay = 1; end
    end else if (req[m_last] && m_burst < MB) begin
      g = m_last; stay = 1;
    end else begin
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_last + k) % NR;
        if (g < 0 && req[c]) g = c;
      end
    end
    load = !rst && g >= 0 && (!m_valid || id_ready);
    exp_rdy = load ? (NR'(1) << g) : '0;
  endtask

  task automatic clk_edge();
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_entry = '0; m_src = 0; m_last = 0; m_burst = 0;
    end else if (load) begin
      m_valid = 1;
      m_entry = entries[g*EW +: EW];
      m_src   = g;
      m_burst = stay ? ((m_burst + 1 > MB) ? MB : m_burst + 1) : 1;
      m_last  = g;
    end else if (m_valid && (id_ready || flush[m_src])) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    eval(); clk_edge();
    eval(); clk_edge();
    rst = 0; hold = 0; flush = '0; valid = '0; id_ready = 1;
  endtask

  task automatic test_reset();
    rst = 1; valid = 2'b11; flush = '0; hold = 0; id_ready = 1;
    entries = {64'h1111, 64'h2222};
    for (int i = 0; i < 2; i++) begin
      eval();
      checks++;
      if (src_ready_o !== 2'b00) begin
        errors++; $display("FAIL reset_ready: got %b want 00", src_ready_o);
      end
      clk_edge();
      checks++;
      if (id_valid_o !== 1'b0 || id_entry_o !== 64'h0 || id_src_o !== 1'b0) begin
        errors++; $display("FAIL reset_state: got v=%b e=%h s=%0d want v=0 e=0 s=0",
                           id_valid_o, id_entry_o, id_src_o);
      end
    end
    rst = 0;
    eval();
    checks++;
    if (src_ready_o !== 2'b01) begin
      errors++; $display("FAIL reset_first_grant: got %b want 01", src_ready_o);
    end
    clk_edge();
    checks++;
    if (id_valid_o !== 1'b1 || id_src_o !== 1'b0 || id_entry_o !== 64'h2222) begin
      errors++; $display("FAIL reset_first_load: got v=%b s=%0d e=%h want v=1 s=0 e=2222",
                         id_valid_o, id_src_o, id_entry_o);
    end
  endtask

  task automatic test_burst();
    int seq [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    do_reset();
    valid = 2'b11; id_ready = 1;
    for (int i = 0; i < 10; i++) begin
      entries = {$urandom, $urandom, $urandom, $urandom};
      eval();
      checks++;
      if (src_ready_o !== (NR'(1) << seq[i]) || src_ready_o !== exp_rdy) begin
        errors++; $display("FAIL burst_grant[%0d]: got %b want %b", i, src_ready_o, NR'(1) << seq[i]);
      end
      clk_edge();
      checks++;
      if (id_src_o !== 1'(seq[i]) || id_entry_o !== m_entry) begin
        errors++; $display("FAIL burst_load[%0d]: got s=%0d e=%h want s=%0d e=%h",
                           i, id_src_o, id_entry_o, seq[i], m_entry);
      end
    end
  endtask

  task automatic test_single_requester();
    do_reset();
    valid = 2'b10; id_ready = 1;
    for (int i = 0; i < 10; i++) begin
      entries = {$urandom, $urandom, $urandom, $urandom};
      eval();
      checks++;
      if (src_ready_o !== 2'b10) begin
        errors++; $display("FAIL single_grant[%0d]: got %b want 10", i, src_ready_o);
      end
      clk_edge();
      checks++;
      if (id_valid_o !== 1'b1 || id_src_o !== 1'b1 || id_entry_o !== m_entry) begin
        errors++; $display("FAIL single_load[%0d]: got v=%b s=%0d e=%h want v=1 s=1 e=%h",
                           i, id_valid_o, id_src_o, id_entry_o, m_entry);
      end
      checks++;
      if (int'(dut.burst_q) > MB || int'(dut.burst_q) != m_burst) begin
        errors++; $display("FAIL single_burst[%0d]: got %0d want %0d", i, dut.burst_q, m_burst);
      end
    end
  endtask

  task automatic test_stall();
    logic [EW-1:0] held;
    do_reset();
    valid = 2'b11; id_ready = 1;
    entries = {64'hBEEF, 64'hCAFE};
    eval(); clk_edge();
    held = 64'hCAFE;
    id_ready = 0;
    for (int i = 0; i < 3; i++) begin
      entries = {$urandom, $urandom, $urandom, $urandom};
      eval();
      checks++;
      if (src_ready_o !== 2'b00) begin
        errors++; $display("FAIL stall_ready[%0d]: got %b want 00", i, src_ready_o);
      end
      clk_edge();
      checks++;
      if (id_valid_o !== 1'b1 || id_entry_o !== held) begin
        errors++; $display("FAIL stall_hold[%0d]: got v=%b e=%h want v=1 e=%h",
                           i, id_valid_o, id_entry_o, held);
      end
    end
    id_ready = 1;
    eval();
    checks++;
    if (src_ready_o === 2'b00 || src_ready_o !== exp_rdy) begin
      errors++; $display("FAIL stall_release: got %b want %b", src_ready_o, exp_rdy);
    end
    clk_edge();
  endtask

  task automatic test_flush();
    do_reset();
    valid = 2'b01; id_ready = 1;
    entries = {64'h3C, 64'hA5};
    eval(); clk_edge();
    checks++;
    if (id_entry_o !== 64'hA5 || id_src_o !== 1'b0) begin
      errors++; $display("FAIL flush_setup: got e=%h s=%0d want e=a5 s=0", id_entry_o, id_src_o);
    end
    valid = 2'b11; flush = 2'b01;
    eval();
    checks++;
    if (src_ready_o !== 2'b10) begin
      errors++; $display("FAIL flush_ready: got %b want 10", src_ready_o);
    end
    clk_edge();
    checks++;
    if (id_valid_o !== 1'b1 || id_entry_o !== 64'h3C || id_src_o !== 1'b1) begin
      errors++; $display("FAIL flush_load: got v=%b e=%h s=%0d want v=1 e=3c s=1",
                         id_valid_o, id_entry_o, id_src_o);
    end
    valid = 2'b00; flush = 2'b01; id_ready = 0;
    eval(); clk_edge();
    checks++;
    if (id_valid_o !== 1'b1 || id_entry_o !== 64'h3C) begin
      errors++; $display("FAIL flush_other: got v=%b e=%h want v=1 e=3c", id_valid_o, id_entry_o);
    end
    flush = 2'b10;
    eval(); clk_edge();
    checks++;
    if (id_valid_o !== 1'b0 || id_entry_o !== 64'h3C || id_src_o !== 1'b1) begin
      errors++; $display("FAIL flush_held: got v=%b e=%h s=%0d want v=0 e=3c s=1",
                         id_valid_o, id_entry_o, id_src_o);
    end
    flush = '0; id_ready = 1;
  endtask

  task automatic test_hold();
    do_reset();
    valid = 2'b10; id_ready = 1;
    entries = {64'h77, 64'h55};
    eval(); clk_edge();
    hold = 1; valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      eval();
      checks++;
      if (src_ready_o !== 2'b00) begin
        errors++; $display("FAIL hold_block[%0d]: got %b want 00", i, src_ready_o);
      end
      clk_edge();
    end
    hold = 0;
    eval();
    checks++;
    if (src_ready_o !== 2'b01) begin
      errors++; $display("FAIL hold_release: got %b want 01", src_ready_o);
    end
    clk_edge();
    checks++;
    if (id_valid_o !== 1'b1 || id_src_o !== 1'b0 || id_entry_o !== 64'h55) begin
      errors++; $display("FAIL hold_load: got v=%b s=%0d e=%h want v=1 s=0 e=55",
                         id_valid_o, id_src_o, id_entry_o);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 99) < 2);
      hold     = ($urandom_range(0, 99) < 10);
      flush    = ($urandom_range(0, 99) < 20) ? NR'($urandom) : '0;
      valid    = NR'($urandom);
      id_ready = ($urandom_range(0, 99) < 70);
      entries  = {$urandom, $urandom, $urandom, $urandom};
      eval();
      checks++;
      if (src_ready_o !== exp_rdy) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, src_ready_o, exp_rdy);
      end
      clk_edge();
      checks++;
      if (id_valid_o !== m_valid || id_entry_o !== m_entry || id_src_o !== 1'(m_src)) begin
        errors++; $display("FAIL rand_out[%0d]: got v=%b e=%h s=%0d want v=%b e=%h s=%0d",
                           i, id_valid_o, id_entry_o, id_src_o, m_valid, m_entry, m_src);
      end
    end
    rst = 0;
  endtask

  initial begin
    m_last = 0; m_burst = 0; m_src = 0; m_valid = 0; m_entry = '0;
    rst = 1; hold = 0; flush = '0; valid = '0; entries = '0; id_ready = 0;
    test_reset();
    test_burst();
    test_single_requester();
    test_stall();
    test_flush();
    test_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
